alu_nbit_seq: RTL

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

---
 rtl/alu_nbit_seq.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_nbit_seq                                                 |
// | Description : Sequential N-bit ALU. AND/OR/ADD/SUB/SLT finish in a single  |
// |               cycle. SRL shifts one bit per cycle. The optional MULU is an |
// |               unsigned shift-add multiplier that takes one bit per cycle.  |
// |               Results are registered and held between valid pulses.        |
// | Options     : define ALU_MULTU_EN to build the MUL state and opcode 100    |
// |               (MULU). Without it, opcode 100 is undefined and hi is 0.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_nbit_seq #(
  parameter int WIDTH = 32   // power of two, 4..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       Signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW  = $clog2(WIDTH);
  // One extra bit so the multiply step count (WIDTH) fits in the counter
  localparam int CNTW = SHW + 1;
  localparam int MSB  = WIDTH - 1;

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SRL  = 3'b011;
  localparam logic [2:0] c_OP_SUB  = 3'b110;
  localparam logic [2:0] c_OP_SLT  = 3'b111;
`ifdef ALU_MULTU_EN
  localparam logic [2:0] c_OP_MULU = 3'b100;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef ALU_MULTU_EN
    ,
    S_MUL   = 2'd2
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_acc;       // SRL: value being shifted; MULU: multiplier / low product
  logic [CNTW-1:0]   r_cnt;       // remaining iterations of the multi-cycle op
  logic              r_valid;
  logic [WIDTH-1:0]  r_result;
  logic              r_zero;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_acc_nxt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              w_wr;        // commit a finished operation to the output registers
  logic [WIDTH-1:0]  w_res_nxt;
  logic              w_ovf_nxt;

`ifdef ALU_MULTU_EN
  logic [WIDTH-1:0]  r_phi;       // running high half of the product
  logic [WIDTH-1:0]  r_mcand;     // captured multiplicand
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  w_phi_nxt;
  logic [WIDTH-1:0]  w_mcand_nxt;
  logic [WIDTH-1:0]  w_hi_nxt;
  logic [WIDTH:0]    w_madd;      // partial sum including carry-out
`endif

  // Single-cycle arithmetic shared by ADD, SUB and SLT
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_diff;
  logic              w_ovf_add;
  logic              w_ovf_sub;
  logic              w_slt;
  logic [SHW-1:0]    w_shamt;
  logic [WIDTH-1:0]  w_shr;

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_ovf_add = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
  // For subtraction B is effectively inverted, so the sign test flips on b
  assign w_ovf_sub = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
  assign w_slt     = w_diff[MSB] ^ w_ovf_sub;
  assign w_shamt   = b[SHW-1:0];
  assign w_shr     = r_acc >> 1;

`ifdef ALU_MULTU_EN
  assign w_madd = {1'b0, r_phi} + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
`endif

  assign ready    = (r_state == S_IDLE);
  assign valid    = r_valid;
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
`ifdef ALU_MULTU_EN
  assign hi       = r_hi;
`else
  assign hi       = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, iteration datapath and result selection
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_res_nxt   = r_result;
    w_ovf_nxt   = 1'b0;
`ifdef ALU_MULTU_EN
    w_phi_nxt   = r_phi;
    w_mcand_nxt = r_mcand;
    w_hi_nxt    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (Signal)
            c_OP_AND: begin
              w_wr      = 1'b1;
              w_res_nxt = a & b;
            end
            c_OP_OR: begin
              w_wr      = 1'b1;
              w_res_nxt = a | b;
            end
            c_OP_ADD: begin
              w_wr      = 1'b1;
              w_res_nxt = w_sum;
              w_ovf_nxt = w_ovf_add;
            end
            c_OP_SUB: begin
              w_wr      = 1'b1;
              w_res_nxt = w_diff;
              w_ovf_nxt = w_ovf_sub;
            end
            c_OP_SLT: begin
              w_wr      = 1'b1;
              w_res_nxt = {{(WIDTH-1){1'b0}}, w_slt};
            end
            c_OP_SRL: begin
              // A zero shift has nothing to iterate, so it finishes now
              if (w_shamt == '0) begin
                w_wr      = 1'b1;
                w_res_nxt = a;
              end else begin
                w_acc_nxt   = a;
                w_cnt_nxt   = {1'b0, w_shamt};
                w_state_nxt = S_SHIFT;
              end
            end
`ifdef ALU_MULTU_EN
            c_OP_MULU: begin
              w_acc_nxt   = b;
              w_mcand_nxt = a;
              w_phi_nxt   = '0;
              w_cnt_nxt   = CNTW'(WIDTH);
              w_state_nxt = S_MUL;
            end
`endif
            default: begin
              w_wr      = 1'b1;
              w_res_nxt = '0;
            end
          endcase
        end
      end
      S_SHIFT: begin
        // The last shift goes straight to the output so valid and IDLE coincide
        if (r_cnt == CNTW'(1)) begin
          w_wr        = 1'b1;
          w_res_nxt   = w_shr;
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt = w_shr;
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
`ifdef ALU_MULTU_EN
      S_MUL: begin
        // Add the multiplicand when the current multiplier bit is set, then
        // shift the {carry, high, low} product right by one
        w_phi_nxt = w_madd[WIDTH:1];
        w_acc_nxt = {w_madd[0], r_acc[WIDTH-1:1]};
        if (r_cnt == CNTW'(1)) begin
          w_wr        = 1'b1;
          w_res_nxt   = w_acc_nxt;
          w_hi_nxt    = w_phi_nxt;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Iteration registers for the multi-cycle ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
`ifdef ALU_MULTU_EN
      r_phi   <= '0;
      r_mcand <= '0;
`endif
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef ALU_MULTU_EN
      r_phi   <= w_phi_nxt;
      r_mcand <= w_mcand_nxt;
`endif
    end
  end

  // Output registers: updated only when an op completes, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
`ifdef ALU_MULTU_EN
      r_hi     <= '0;
`endif
    end else begin
      r_valid <= w_wr;
      if (w_wr) begin
        r_result <= w_res_nxt;
        r_zero   <= (w_res_nxt == '0);
        r_ovf    <= w_ovf_nxt;
`ifdef ALU_MULTU_EN
        r_hi     <= w_hi_nxt;
`endif
      end
    end
  end

endmodule
`default_nettype wire
